// File: rtl/phase_sequencer.sv
// Instruction phase sequencer: steps FETCH/DECODE/EXECUTE/UPDATE with minimum phase
// length, WAIT stretching of FETCH/EXECUTE, run/step/halt control and a retired count.
module phase_sequencer #(
    parameter int unsigned PHASE_LEN = 1,
    parameter int unsigned ICNT_W    = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RUN,
    input  logic              STEP,
    input  logic              HALT_REQ,
    input  logic              WAIT,
    output logic [1:0]        PH,
    output logic              PH_STROBE,
    output logic              BUSY,
    output logic              INSTR_DONE,
    output logic [ICNT_W-1:0] ICNT
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHASE_LEN - 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DECODE  = 2'd1,
        EXECUTE = 2'd2,
        UPDATE  = 2'd3
    } phase_t;

    state_t            state_q, state_d;
    phase_t            ph_q, ph_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              halt_q, halt_d;
    logic              step_q, step_d;
    logic              strobe_q, strobe_d;
    logic              busy_q, busy_d;
    logic [ICNT_W-1:0] icnt_q, icnt_d;

    logic last_cycle;
    logic stretch;
    logic boundary;

    assign last_cycle = (cnt_q == CNT_LAST);
    assign stretch    = WAIT && ((ph_q == FETCH) || (ph_q == EXECUTE));
    assign boundary   = (state_q == ACTIVE) && (ph_q == UPDATE) && last_cycle;

    // State register; idle parks on EXECUTE so the downstream controller enables nothing
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            ph_q     <= EXECUTE;
            cnt_q    <= '0;
            halt_q   <= 1'b0;
            step_q   <= 1'b0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            icnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            ph_q     <= ph_d;
            cnt_q    <= cnt_d;
            halt_q   <= halt_d;
            step_q   <= step_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
            icnt_q   <= icnt_d;
        end
    end

    // Next-state and registered-output decode
    always_comb begin
        state_d  = state_q;
        ph_d     = ph_q;
        cnt_d    = cnt_q;
        halt_d   = halt_q;
        step_d   = step_q;
        strobe_d = 1'b0;
        busy_d   = busy_q;
        icnt_d   = icnt_q;

        case (state_q)
            IDLE: begin
                if (RUN || STEP) begin
                    state_d  = ACTIVE;
                    ph_d     = FETCH;
                    cnt_d    = '0;
                    strobe_d = 1'b1;
                    busy_d   = 1'b1;
                    step_d   = STEP && !RUN;
                end
            end
            ACTIVE: begin
                halt_d = halt_q || HALT_REQ;
                if (!last_cycle) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (!stretch) begin
                    cnt_d = '0;
                    if (ph_q == UPDATE) begin
                        icnt_d = icnt_q + ICNT_W'(1);
                        if (halt_q || HALT_REQ || step_q || !RUN) begin
                            state_d = IDLE;
                            ph_d    = EXECUTE;
                            busy_d  = 1'b0;
                            halt_d  = 1'b0;
                            step_d  = 1'b0;
                        end else begin
                            ph_d     = FETCH;
                            strobe_d = 1'b1;
                        end
                    end else begin
                        ph_d     = phase_t'(ph_q + 2'd1);
                        strobe_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign PH         = ph_q;
    assign PH_STROBE  = strobe_q;
    assign BUSY       = busy_q;
    assign ICNT       = icnt_q;
    assign INSTR_DONE = boundary;

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: two configurations driven by directed sequences, checked
// every cycle against a phase-level model plus hand-computed literal expectations.
module tb_phase_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: PHASE_LEN=1, ICNT_W=4 (free run, step, halt, wrap)
    logic       a_rst = 1'b1, a_run = 1'b0, a_step = 1'b0, a_halt = 1'b0, a_wait = 1'b0;
    logic [1:0] a_ph;
    logic       a_strobe, a_busy, a_done;
    logic [3:0] a_icnt;

    // Instance B: PHASE_LEN=2, ICNT_W=16 (wait stretch, reset mid-phase)
    logic        b_rst = 1'b1, b_run = 1'b0, b_step = 1'b0, b_halt = 1'b0, b_wait = 1'b0;
    logic [1:0]  b_ph;
    logic        b_strobe, b_busy, b_done;
    logic [15:0] b_icnt;

    phase_sequencer #(.PHASE_LEN(1), .ICNT_W(4)) u_a (
        .CLK(clk), .RST(a_rst), .RUN(a_run), .STEP(a_step), .HALT_REQ(a_halt), .WAIT(a_wait),
        .PH(a_ph), .PH_STROBE(a_strobe), .BUSY(a_busy), .INSTR_DONE(a_done), .ICNT(a_icnt)
    );

    phase_sequencer #(.PHASE_LEN(2), .ICNT_W(16)) u_b (
        .CLK(clk), .RST(b_rst), .RUN(b_run), .STEP(b_step), .HALT_REQ(b_halt), .WAIT(b_wait),
        .PH(b_ph), .PH_STROBE(b_strobe), .BUSY(b_busy), .INSTR_DONE(b_done), .ICNT(b_icnt)
    );

    task automatic check(input string nm, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // Behavioural model: where in the instruction we are and how long we've been there
    typedef struct {
        bit active;
        int ph;
        int age;
        bit halt;
        bit single;
        int cnt;
        bit strobe;
    } mdl_t;

    function automatic mdl_t mstep(mdl_t m, int pl, int w, bit rst, bit run, bit stp,
                                   bit hreq, bit wt);
        mdl_t n = m;
        n.strobe = 1'b0;
        if (rst) begin
            n = '{default: 0};
            return n;
        end
        if (!m.active) begin
            if (run || stp) begin
                n.active = 1'b1;
                n.ph     = 0;
                n.age    = 0;
                n.strobe = 1'b1;
                n.single = !run;
            end
            return n;
        end
        n.halt = m.halt || hreq;
        if (m.age < pl - 1) begin
            n.age = m.age + 1;
            return n;
        end
        if ((m.ph == 0 || m.ph == 2) && wt) return n;
        n.age = 0;
        if (m.ph == 3) begin
            n.cnt = (m.cnt + 1) % (1 << w);
            if (n.halt || m.single || !run) begin
                n.active = 1'b0;
                n.halt   = 1'b0;
                n.single = 1'b0;
            end else begin
                n.ph     = 0;
                n.strobe = 1'b1;
            end
        end else begin
            n.ph     = m.ph + 1;
            n.strobe = 1'b1;
        end
        return n;
    endfunction

    mdl_t ma = '{default: 0};
    mdl_t mb = '{default: 0};
    bit   a_valid = 1'b0;
    bit   b_valid = 1'b0;

    always @(posedge clk) begin
        ma      <= mstep(ma, 1, 4, a_rst, a_run, a_step, a_halt, a_wait);
        mb      <= mstep(mb, 2, 16, b_rst, b_run, b_step, b_halt, b_wait);
        a_valid <= a_valid | a_rst;
        b_valid <= b_valid | b_rst;
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (a_valid) begin
            check("a_model_ph", int'(a_ph), ma.active ? ma.ph : 2);
            check("a_model_strobe", int'(a_strobe), int'(ma.strobe));
            check("a_model_busy", int'(a_busy), int'(ma.active));
            check("a_model_done", int'(a_done), int'(ma.active && ma.ph == 3 && ma.age == 0));
            check("a_model_icnt", int'(a_icnt), ma.cnt);
        end
        if (b_valid) begin
            check("b_model_ph", int'(b_ph), mb.active ? mb.ph : 2);
            check("b_model_strobe", int'(b_strobe), int'(mb.strobe));
            check("b_model_busy", int'(b_busy), int'(mb.active));
            check("b_model_done", int'(b_done), int'(mb.active && mb.ph == 3 && mb.age == 1));
            check("b_model_icnt", int'(b_icnt), mb.cnt);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_a();
        a_rst = 1'b1;
        cyc(2);
        check("a_rst_ph", int'(a_ph), 2);
        check("a_rst_busy", int'(a_busy), 0);
        check("a_rst_strobe", int'(a_strobe), 0);
        check("a_rst_icnt", int'(a_icnt), 0);
        a_rst = 1'b0;
        a_run = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cyc(1);
            check("a_free_ph", int'(a_ph), (k - 1) % 4);
            check("a_free_strobe", int'(a_strobe), 1);
            check("a_free_done", int'(a_done), ((k - 1) % 4 == 3) ? 1 : 0);
        end
        cyc(1);
        check("a_free_icnt3", int'(a_icnt), 3);
        check("a_free_refetch", int'(a_ph), 0);
        cyc(2);
        check("a_halt_in_exec", int'(a_ph), 2);
        a_halt = 1'b1;
        cyc(1);
        a_halt = 1'b0;
        check("a_halt_done", int'(a_done), 1);
        cyc(1);
        check("a_halt_idle_ph", int'(a_ph), 2);
        check("a_halt_idle_busy", int'(a_busy), 0);
        check("a_halt_idle_icnt", int'(a_icnt), 4);
        cyc(1);
        check("a_halt_restart_ph", int'(a_ph), 0);
        check("a_halt_restart_busy", int'(a_busy), 1);
        for (int k = 5; k <= 18; k++) begin
            check("a_wrap_icnt", int'(a_icnt), (k - 1) % 16);
            cyc(4);
        end
        a_run = 1'b0;
        cyc(3);
        check("a_runfall_update", int'(a_ph), 3);
        check("a_runfall_done", int'(a_done), 1);
        cyc(1);
        check("a_runfall_idle", int'(a_busy), 0);
        check("a_runfall_icnt", int'(a_icnt), 3);
        a_halt = 1'b1;
        cyc(1);
        a_halt = 1'b0;
        check("a_idle_halt_busy", int'(a_busy), 0);
        a_step = 1'b1;
        cyc(1);
        a_step = 1'b0;
        check("a_step_fetch", int'(a_ph), 0);
        check("a_step_busy", int'(a_busy), 1);
        cyc(1);
        check("a_step_decode", int'(a_ph), 1);
        a_step = 1'b1;
        cyc(1);
        a_step = 1'b0;
        cyc(1);
        check("a_step_done", int'(a_done), 1);
        cyc(1);
        check("a_step_idle_ph", int'(a_ph), 2);
        check("a_step_idle_busy", int'(a_busy), 0);
        check("a_step_icnt", int'(a_icnt), 4);
        cyc(2);
        check("a_step_stays_idle", int'(a_busy), 0);
        check("a_step_ignored_icnt", int'(a_icnt), 4);
        a_run  = 1'b1;
        a_step = 1'b1;
        cyc(1);
        a_step = 1'b0;
        check("a_both_fetch", int'(a_ph), 0);
        cyc(4);
        check("a_both_continue_ph", int'(a_ph), 0);
        check("a_both_continue_busy", int'(a_busy), 1);
        check("a_both_icnt", int'(a_icnt), 5);
        cyc(2);
        a_rst = 1'b1;
        cyc(1);
        check("a_midrst_ph", int'(a_ph), 2);
        check("a_midrst_busy", int'(a_busy), 0);
        check("a_midrst_icnt", int'(a_icnt), 0);
        a_rst = 1'b0;
        cyc(1);
        check("a_postrst_fetch", int'(a_ph), 0);
        check("a_postrst_strobe", int'(a_strobe), 1);
        cyc(4);
    endtask

    task automatic run_b();
        b_rst = 1'b1;
        cyc(2);
        check("b_rst_ph", int'(b_ph), 2);
        check("b_rst_busy", int'(b_busy), 0);
        b_rst = 1'b0;
        b_run = 1'b1;
        cyc(1);
        check("b_fetch_first_ph", int'(b_ph), 0);
        check("b_fetch_first_strobe", int'(b_strobe), 1);
        cyc(1);
        check("b_fetch_last_ph", int'(b_ph), 0);
        check("b_fetch_last_strobe", int'(b_strobe), 0);
        b_wait = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            check("b_stretch_ph", int'(b_ph), 0);
            check("b_stretch_strobe", int'(b_strobe), 0);
        end
        b_wait = 1'b0;
        cyc(1);
        check("b_decode_ph", int'(b_ph), 1);
        check("b_decode_strobe", int'(b_strobe), 1);
        b_wait = 1'b1;
        cyc(1);
        check("b_decode2_ph", int'(b_ph), 1);
        cyc(1);
        check("b_exec_ph", int'(b_ph), 2);
        check("b_exec_strobe", int'(b_strobe), 1);
        b_halt = 1'b1;
        cyc(1);
        b_halt = 1'b0;
        check("b_exec2_ph", int'(b_ph), 2);
        cyc(1);
        check("b_exec_stretch_ph", int'(b_ph), 2);
        check("b_exec_stretch_strobe", int'(b_strobe), 0);
        check("b_exec_stretch_busy", int'(b_busy), 1);
        b_rst = 1'b1;
        cyc(1);
        check("b_midrst_ph", int'(b_ph), 2);
        check("b_midrst_busy", int'(b_busy), 0);
        check("b_midrst_icnt", int'(b_icnt), 0);
        check("b_midrst_strobe", int'(b_strobe), 0);
        b_rst  = 1'b0;
        b_wait = 1'b0;
        cyc(1);
        check("b_postrst_ph", int'(b_ph), 0);
        check("b_postrst_strobe", int'(b_strobe), 1);
        check("b_postrst_busy", int'(b_busy), 1);
        cyc(16);
        check("b_nohalt_ph", int'(b_ph), 0);
        check("b_nohalt_busy", int'(b_busy), 1);
        check("b_nohalt_icnt", int'(b_icnt), 2);
    endtask

    initial begin
        fork
            run_a();
            run_b();
        join
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Generates the 2-bit instruction phase PH (FETCH, DECODE, EXECUTE, UPDATE) that drives the sequence controller directly downstream.
- Supports three operating modes: free-run, single-step, and halt at an instruction boundary.
- Each phase lasts a minimum number of cycles and can be stretched by a wait input during FETCH and EXECUTE, which is how slow RAM/IO accesses are absorbed.
- Counts retired instructions.

Parameters:
- PHASE_LEN, default 1: minimum cycles per phase; legal range 1..15.
- ICNT_W, default 16: width of the retired-instruction counter.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge
- RST  in  1  synchronous, active-high reset
- RUN  in  1  level; high = free-run sequencing
- STEP  in  1  pulse; while idle, runs exactly one instruction
- HALT_REQ  in  1  pulse; stop at the next instruction boundary
- WAIT  in  1  stretches FETCH/EXECUTE while high
- PH  out  2  phase: FETCH=0, DECODE=1, EXECUTE=2, UPDATE=3
- PH_STROBE  out  1  high on the first cycle of each new phase
- BUSY  out  1  high while an instruction is in progress
- INSTR_DONE  out  1  one-cycle pulse on the final UPDATE cycle
- ICNT  out  ICNT_W  retired-instruction count

Behaviour:
- Reset: RST is synchronous and active-high and overrides every other input.
  - State = IDLE, PH=EXECUTE (2), PH_STROBE=0, BUSY=0, INSTR_DONE=0, ICNT=0.
  - Internal phase counter = 0; halt latch and step flag cleared.
- Why IDLE parks on EXECUTE: in EXECUTE the controller asserts nothing, so no register or PC enable is active while idle.
- Top FSM has two states:
  - IDLE → ACTIVE when RUN=1, or when STEP=1 with RUN=0.
    - If both are high, RUN wins and the STEP flag is not set.
    - STEP=1 with RUN=0 sets the step flag.
  - On entering ACTIVE: PH=FETCH and PH_STROBE=1 on the same edge, BUSY=1. The first FETCH cycle is the cycle after the start condition is sampled.
  - ACTIVE runs phases in order FETCH → DECODE → EXECUTE → UPDATE → FETCH …
- Phase duration:
  - The phase counter counts 0..PHASE_LEN-1 and resets to 0 on each phase change.
  - A phase ends on the cycle where counter == PHASE_LEN-1.
  - Exception: in FETCH or EXECUTE with WAIT=1 on that cycle, PH and the counter hold until a cycle with WAIT=1 is no longer present.
  - WAIT is ignored in DECODE and UPDATE, and ignored while IDLE.
  - WAIT asserted before the final cycle has no effect; only the final cycle is qualified.
  - With PHASE_LEN=1 and WAIT=0, PH changes every cycle (4 cycles per instruction).
- PH_STROBE is high only in cycle 0 of a phase. A stretched phase does not re-strobe.
- Instruction boundary = final UPDATE cycle (counter == PHASE_LEN-1). On that cycle:
  - INSTR_DONE=1 for exactly that cycle (combinational from state, or registered so that it aligns with that cycle; must align).
  - ICNT increments on the following edge. It wraps from 2^ICNT_W-1 to 0 with no flag.
  - Next state is IDLE (PH←EXECUTE, BUSY←0, halt latch and step flag cleared) if any of these holds: the halt latch is set, the step flag is set, or RUN=0. Otherwise the next state is FETCH with a strobe.
- HALT_REQ:
  - Sampled in ACTIVE: sets a sticky latch. If it coincides with the boundary cycle, it takes effect at that boundary.
  - Ignored in IDLE; never latched there.
- RUN falling mid-instruction: the instruction completes, then the block goes IDLE. There is no abort.
- STEP while ACTIVE: ignored.
- RUN held high while HALT_REQ forces IDLE: the block restarts FETCH on the cycle after entering IDLE. That is, there is one IDLE cycle minimum between instructions.
- Reset mid-phase: the next cycle is in reset state regardless of WAIT, counter, or latches.
- All outputs are registered except INSTR_DONE, which may be decoded from registered state.

Test Plan:
- Free-run: PHASE_LEN=1, RST then RUN=1 held for 12 cycles → PH sequence 0,1,2,3 repeating from cycle 1 after start; PH_STROBE high every cycle; INSTR_DONE on every 4th cycle; ICNT=3 after 3 full instructions.
- Single-step: RUN=0, pulse STEP once → exactly one instruction (0,1,2,3), then PH=2, BUSY=0, ICNT=1. A STEP pulsed during DECODE is ignored (ICNT remains 1).
- Wait stretch: PHASE_LEN=2, WAIT=1 for 3 cycles starting at the last FETCH cycle → FETCH lasts 5 cycles, PH_STROBE high only on its first cycle. WAIT=1 during DECODE → DECODE still 2 cycles.
- Halt: RUN=1, HALT_REQ pulse during EXECUTE of instruction 2 → instruction 2 completes (INSTR_DONE), then PH=2, BUSY=0 for exactly 1 cycle, then FETCH restarts because RUN is still 1. HALT_REQ while IDLE → no effect.
- Wrap and simultaneity: ICNT_W=4, run 17 instructions → ICNT goes 15→0→1. RUN=1 and STEP=1 in the same idle cycle → continuous run, no stop after one instruction.
- Reset mid-operation: RST=1 during a stretched EXECUTE with WAIT=1 and the halt latch set → next cycle PH=2, BUSY=0, ICNT=0, PH_STROBE=0. After RST releases with RUN=1, FETCH starts on the next cycle.
